dm_store_buffer: RTL and testbench

- Data-memory block directly downstream of the 5-stage CPU's MEM stage.
- Consumes the CPU's address, store data, write strobe and `dm_type` outputs; returns load data on the CPU's `Data_in` port.
- Contains a word-organised RAM with byte-lane writes and a 1-entry registered store buffer, with load forwarding from that buffer.
- Performs load sign/zero extension and detects misaligned accesses, which it reports via a flag and a saturating counter.

---
 rtl/dm_store_buffer_pkg.sv | 20 ++
 rtl/dm_store_buffer_if.sv | 24 ++
 rtl/dm_store_buffer_load_ext.sv | 31 +++
 rtl/dm_store_buffer.sv | 133 +++++++++++++
 tb/tb_dm_store_buffer.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/dm_store_buffer_pkg.sv
// Shared data-memory access-size encoding (mirrors ctrl_encode_def.v) and the alignment rule
// used by both the store path and the load extender.
package dm_store_buffer_pkg;

  localparam logic [2:0] dm_word              = 3'b000;
  localparam logic [2:0] dm_halfword          = 3'b001;
  localparam logic [2:0] dm_halfword_unsigned = 3'b010;
  localparam logic [2:0] dm_byte              = 3'b011;
  localparam logic [2:0] dm_byte_unsigned     = 3'b100;

  // Undefined codes fall into the default arm and are checked as word accesses.
  function automatic logic dm_aligned(input logic [2:0] dm_type, input logic [1:0] lane);
    case (dm_type)
      dm_halfword, dm_halfword_unsigned: return ~lane[0];
      dm_byte, dm_byte_unsigned:         return 1'b1;
      default:                           return lane == 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dm_store_buffer_if.sv
// CPU MEM-stage <-> data memory bus. The CPU side is the master; the memory block is the slave.
interface dm_store_buffer_if #(
  parameter int ERR_CNT_W = 8
);
  logic                 mem_w;
  logic                 mem_r;
  logic [31:0]          addr;
  logic [31:0]          wdata;
  logic [2:0]           dm_type;
  logic [31:0]          rdata;
  logic                 misalign;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 buf_valid;

  modport master (
    output mem_w, mem_r, addr, wdata, dm_type,
    input  rdata, misalign, err_cnt, buf_valid
  );

  modport slave (
    input  mem_w, mem_r, addr, wdata, dm_type,
    output rdata, misalign, err_cnt, buf_valid
  );
endinterface

// File: rtl/dm_store_buffer_load_ext.sv
// Load lane select and sign/zero extension. Misaligned accesses read from lane 0 of the word.
module dm_load_ext
  import dm_store_buffer_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_dm_type,
  output logic [31:0] o_data
);

  logic [1:0]  w_lane;
  logic [15:0] w_half;
  logic [7:0]  w_byte;

  assign w_lane = dm_aligned(i_dm_type, i_lane) ? i_lane : 2'b00;
  assign w_half = w_lane[1] ? i_word[31:16] : i_word[15:0];
  assign w_byte = i_word[{w_lane, 3'b000} +: 8];

  // NOTE: assign a default before the case so every path drives o_data; otherwise a latch is inferred.
  always_comb begin
    o_data = i_word;
    case (i_dm_type)
      dm_halfword:          o_data = {{16{w_half[15]}}, w_half};
      dm_halfword_unsigned: o_data = {16'h0000, w_half};
      dm_byte:              o_data = {{24{w_byte[7]}}, w_byte};
      dm_byte_unsigned:     o_data = {24'h000000, w_byte};
      default:              o_data = i_word;
    endcase
  end

endmodule

// File: rtl/dm_store_buffer.sv
// Word-organised data RAM with byte-lane writes, misalignment detection and a saturating error count.
// Define DM_STORE_BUFFER_EN to insert a 1-entry store buffer with load forwarding in front of the RAM.
module dm_store_buffer
  import dm_store_buffer_pkg::*;
#(
  parameter int ADDR_WORDS_LOG2 = 7,
  parameter int ERR_CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  dm_store_buffer_if.slave  bus
);

  localparam int IW = ADDR_WORDS_LOG2;

  logic [31:0]          r_mem [0:(1<<IW)-1];
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic [IW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic          w_aligned;
  logic          w_misalign;
  logic          w_store_ok;
  logic [3:0]    w_st_mask;
  logic [31:0]   w_st_data;
  logic [31:0]   w_word;
  logic          w_we;
  logic [IW-1:0] w_we_idx;
  logic [3:0]    w_we_mask;
  logic [31:0]   w_we_data;
  logic          w_unused;

  // Upper address bits are dropped so accesses alias modulo the RAM size.
  assign w_idx      = bus.addr[IW+1:2];
  assign w_lane     = bus.addr[1:0];
  assign w_unused   = ^bus.addr[31:IW+2];
  assign w_aligned  = dm_aligned(bus.dm_type, w_lane);
  assign w_misalign = (bus.mem_w | bus.mem_r) & ~w_aligned;
  assign w_store_ok = bus.mem_w & w_aligned;

  always_comb begin
    w_st_mask = 4'b1111;
    w_st_data = bus.wdata;
    case (bus.dm_type)
      dm_halfword, dm_halfword_unsigned: begin
        w_st_mask = w_lane[1] ? 4'b1100 : 4'b0011;
        w_st_data = w_lane[1] ? {bus.wdata[15:0], 16'h0000} : {16'h0000, bus.wdata[15:0]};
      end
      dm_byte, dm_byte_unsigned: begin
        w_st_mask = 4'b0001 << w_lane;
        w_st_data = {24'h000000, bus.wdata[7:0]} << {w_lane, 3'b000};
      end
      default: ;
    endcase
  end

`ifdef DM_STORE_BUFFER_EN
  logic          r_buf_valid;
  logic [IW-1:0] r_buf_idx;
  logic [3:0]    r_buf_mask;
  logic [31:0]   r_buf_data;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf_valid <= 1'b0;
      r_buf_idx   <= '0;
      r_buf_mask  <= '0;
      r_buf_data  <= '0;
    end else begin
      r_buf_valid <= w_store_ok;
      if (w_store_ok) begin
        r_buf_idx  <= w_idx;
        r_buf_mask <= w_st_mask;
        r_buf_data <= w_st_data;
      end
    end
  end

  // The pending entry commits on the edge after it was accepted.
  assign w_we      = r_buf_valid;
  assign w_we_idx  = r_buf_idx;
  assign w_we_mask = r_buf_mask;
  assign w_we_data = r_buf_data;

  always_comb begin
    w_word = r_mem[w_idx];
    if (r_buf_valid && (r_buf_idx == w_idx)) begin
      for (int b = 0; b < 4; b++) begin
        if (r_buf_mask[b]) w_word[8*b +: 8] = r_buf_data[8*b +: 8];
      end
    end
  end

  assign bus.buf_valid = r_buf_valid;
`else
  assign w_we      = w_store_ok;
  assign w_we_idx  = w_idx;
  assign w_we_mask = w_st_mask;
  assign w_we_data = w_st_data;
  assign w_word    = r_mem[w_idx];

  assign bus.buf_valid = 1'b0;
`endif

  // NOTE: the RAM array has no reset; it is a plain clocked write port so it maps onto memory macros.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_we_mask[b]) r_mem[w_we_idx][8*b +: 8] <= w_we_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_cnt <= '0;
    end else if (w_misalign && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  dm_load_ext u_load_ext (
    .i_word    (w_word),
    .i_lane    (w_lane),
    .i_dm_type (bus.dm_type),
    .o_data    (bus.rdata)
  );

  assign bus.misalign = w_misalign;
  assign bus.err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed bench for dm_store_buffer: a vector table for the main load/store traffic plus
// hand-written sequences for reset, buffer occupancy, mid-store reset and counter saturation.
module tb_dm_store_buffer;
  import dm_store_buffer_pkg::*;

`ifdef DM_STORE_BUFFER_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  dm_store_buffer_if #(.ERR_CNT_W(8)) bus ();

  dm_store_buffer #(.ADDR_WORDS_LOG2(7), .ERR_CNT_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        mem_w;
    logic        mem_r;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  dm_type;
    bit          chk_rdata;
    logic [31:0] exp_rdata;
    logic        exp_misalign;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later, well before the rising edge.
  task automatic drive(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] t);
    @(negedge clk);
    bus.mem_w   = w;
    bus.mem_r   = r;
    bus.addr    = a;
    bus.wdata   = d;
    bus.dm_type = t;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, dm_word);
  endtask

  function automatic vec_t mk(input string n, input logic w, input logic r, input logic [31:0] a,
                              input logic [31:0] d, input logic [2:0] t, input bit c,
                              input logic [31:0] er, input logic em, input logic [7:0] ee);
    vec_t v;
    v.name = n; v.mem_w = w; v.mem_r = r; v.addr = a; v.wdata = d; v.dm_type = t;
    v.chk_rdata = c; v.exp_rdata = er; v.exp_misalign = em; v.exp_err = ee;
    return v;
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    bus.mem_w = 1'b0; bus.mem_r = 1'b0; bus.addr = '0; bus.wdata = '0; bus.dm_type = dm_word;

    // err_cnt shown is the value visible during that row, before its own edge.
    vecs.push_back(mk("sw_10",        1, 0, 32'h10,  32'h8000_00FF, dm_word,              0, 32'h0,          0, 8'd0));
    vecs.push_back(mk("lb_10_fwd",    0, 1, 32'h10,  32'h0,         dm_byte,              1, 32'hFFFF_FFFF,  0, 8'd0));
    vecs.push_back(mk("lbu_10",       0, 1, 32'h10,  32'h0,         dm_byte_unsigned,     1, 32'h0000_00FF,  0, 8'd0));
    vecs.push_back(mk("lw_10",        0, 1, 32'h10,  32'h0,         dm_word,              1, 32'h8000_00FF,  0, 8'd0));
    vecs.push_back(mk("sw_20",        1, 0, 32'h20,  32'h1122_3344, dm_word,              0, 32'h0,          0, 8'd0));
    vecs.push_back(mk("sb_21",        1, 0, 32'h21,  32'h1234_56AA, dm_byte,              0, 32'h0,          0, 8'd0));
    vecs.push_back(mk("sh_22",        1, 0, 32'h22,  32'h9999_BEEF, dm_halfword,          0, 32'h0,          0, 8'd0));
    vecs.push_back(mk("lw_20_merge",  0, 1, 32'h20,  32'h0,         dm_word,              1, 32'hBEEF_AA44,  0, 8'd0));
    vecs.push_back(mk("lh_22",        0, 1, 32'h22,  32'h0,         dm_halfword,          1, 32'hFFFF_BEEF,  0, 8'd0));
    vecs.push_back(mk("lhu_22",       0, 1, 32'h22,  32'h0,         dm_halfword_unsigned, 1, 32'h0000_BEEF,  0, 8'd0));
    vecs.push_back(mk("lb_21",        0, 1, 32'h21,  32'h0,         dm_byte,              1, 32'hFFFF_FFAA,  0, 8'd0));
    vecs.push_back(mk("lbu_23",       0, 1, 32'h23,  32'h0,         dm_byte_unsigned,     1, 32'h0000_00BE,  0, 8'd0));
    vecs.push_back(mk("lh_20",        0, 1, 32'h20,  32'h0,         dm_halfword,          1, 32'hFFFF_AA44,  0, 8'd0));
    vecs.push_back(mk("sw_13_mis",    1, 0, 32'h13,  32'hDEAD_BEEF, dm_word,              1, 32'h8000_00FF,  1, 8'd0));
    vecs.push_back(mk("lw_10_kept",   0, 1, 32'h10,  32'h0,         dm_word,              1, 32'h8000_00FF,  0, 8'd1));
    vecs.push_back(mk("lw_22_mis",    0, 1, 32'h22,  32'h0,         dm_word,              1, 32'hBEEF_AA44,  1, 8'd1));
    vecs.push_back(mk("lh_21_mis",    0, 1, 32'h21,  32'h0,         dm_halfword,          1, 32'hFFFF_AA44,  1, 8'd2));
    vecs.push_back(mk("lw_13_noreq",  0, 0, 32'h13,  32'h0,         dm_word,              1, 32'h8000_00FF,  0, 8'd3));
    vecs.push_back(mk("t7_20",        0, 1, 32'h20,  32'h0,         3'b111,               1, 32'hBEEF_AA44,  0, 8'd3));
    vecs.push_back(mk("t7_22_mis",    0, 1, 32'h22,  32'h0,         3'b111,               1, 32'hBEEF_AA44,  1, 8'd3));
    vecs.push_back(mk("sw_210_alias", 1, 0, 32'h210, 32'hCAFE_F00D, dm_word,              0, 32'h0,          0, 8'd4));
    vecs.push_back(mk("lw_10_alias",  0, 1, 32'h10,  32'h0,         dm_word,              1, 32'hCAFE_F00D,  0, 8'd4));
    vecs.push_back(mk("lw_210",       0, 1, 32'h210, 32'h0,         dm_word,              1, 32'hCAFE_F00D,  0, 8'd4));
    vecs.push_back(mk("lhu_12",       0, 1, 32'h12,  32'h0,         dm_halfword_unsigned, 1, 32'h0000_CAFE,  0, 8'd4));
    vecs.push_back(mk("lhu_11_mis",   0, 1, 32'h11,  32'h0,         dm_halfword_unsigned, 1, 32'h0000_F00D,  1, 8'd4));
    vecs.push_back(mk("lbu_13",       0, 1, 32'h13,  32'h0,         dm_byte_unsigned,     1, 32'h0000_00CA,  0, 8'd5));

    // Reset and idle.
    reset_n = 1'b0;
    #12;
    check("rst_buf_valid", {31'h0, bus.buf_valid}, 32'h0);
    check("rst_err_cnt", {24'h0, bus.err_cnt}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    idle();
    idle();
    check("idle_buf_valid", {31'h0, bus.buf_valid}, 32'h0);
    check("idle_err_cnt", {24'h0, bus.err_cnt}, 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].mem_w, vecs[i].mem_r, vecs[i].addr, vecs[i].wdata, vecs[i].dm_type);
      check({vecs[i].name, "_misalign"}, {31'h0, bus.misalign}, {31'h0, vecs[i].exp_misalign});
      check({vecs[i].name, "_err_cnt"}, {24'h0, bus.err_cnt}, {24'h0, vecs[i].exp_err});
      if (vecs[i].chk_rdata) check({vecs[i].name, "_rdata"}, bus.rdata, vecs[i].exp_rdata);
    end
    idle();
    check("table_end_err_cnt", {24'h0, bus.err_cnt}, 32'd5);

    // Buffer occupancy: set for one cycle after an accepted store, never for a dropped one.
    drive(1'b1, 1'b0, 32'h40, 32'h0102_0304, dm_word);
    idle();
    check("bv_after_store", {31'h0, bus.buf_valid}, {31'h0, BUF_EN});
    idle();
    check("bv_drained", {31'h0, bus.buf_valid}, 32'h0);
    drive(1'b1, 1'b0, 32'h42, 32'hFFFF_FFFF, dm_word);
    idle();
    check("bv_after_mis_store", {31'h0, bus.buf_valid}, 32'h0);
    drive(1'b0, 1'b1, 32'h40, 32'h0, dm_word);
    check("mis_store_dropped", bus.rdata, 32'h0102_0304);

    // Reset asserted while a store is still pending in the buffer.
    drive(1'b1, 1'b0, 32'h30, 32'h5566_7788, dm_word);
    idle();
    idle();
    drive(1'b1, 1'b0, 32'h30, 32'h99AA_BBCC, dm_word);
    @(posedge clk);
    #1;
    bus.mem_w = 1'b0;
    reset_n   = 1'b0;
    #1;
    check("midrst_buf_valid", {31'h0, bus.buf_valid}, 32'h0);
    check("midrst_err_cnt", {24'h0, bus.err_cnt}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b0, 1'b1, 32'h30, 32'h0, dm_word);
    check("midrst_lw_30", bus.rdata, BUF_EN ? 32'h5566_7788 : 32'h99AA_BBCC);

    // Saturation of the misalignment counter.
    for (int n = 0; n < 300; n++) drive(1'b0, 1'b1, 32'h01, 32'h0, dm_word);
    idle();
    check("err_cnt_sat", {24'h0, bus.err_cnt}, 32'h0000_00FF);
    drive(1'b1, 1'b0, 32'h02, 32'h0, dm_word);
    idle();
    check("err_cnt_hold", {24'h0, bus.err_cnt}, 32'h0000_00FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
